// File: rtl/io_input_arbiter.sv
// Round-robin arbiter that funnels NUM_SOURCES IO devices into the CPU input buffer.
// One word is in flight at a time: write strobe, then hold until the CPU consumes it.
module io_input_arbiter #(
  parameter int  NUM_SOURCES = 4,
  localparam int SRC_W       = $clog2(NUM_SOURCES)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_SOURCES-1:0]    src_valid,
  input  logic [32*NUM_SOURCES-1:0] src_data,
  output logic [NUM_SOURCES-1:0]    src_ack,
  output logic                      buf_write,
  output logic [31:0]               buf_data,
  input  logic                      cpu_consume,
  input  logic                      cfg_write,
  input  logic [NUM_SOURCES-1:0]    cfg_mask,
  input  logic                      flush,
  output logic                      data_ready,
  output logic [SRC_W-1:0]          src_id,
  output logic [7:0]                overrun_count,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [NUM_SOURCES-1:0] mask_q;
  logic [SRC_W-1:0]       last_grant_q;
  logic [NUM_SOURCES-1:0] src_ack_q;
  logic                   buf_write_q;
  logic [31:0]            buf_data_q;
  logic                   data_ready_q;
  logic [SRC_W-1:0]       src_id_q;
  logic [7:0]             overrun_q;

  logic [NUM_SOURCES-1:0] req;
  logic [SRC_W-1:0]       grant_d;
  logic [SRC_W-1:0]       cand;
  logic [NUM_SOURCES-1:0] ack_d;
  logic                   found;

  // Handshake: a source holds src_valid (level) until it sees its one-cycle
  // src_ack pulse; that pulse coincides with buf_write carrying its word.
  always_comb begin
    req     = src_valid & mask_q;
    grant_d = last_grant_q;
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_SOURCES; i++) begin
      cand = SRC_W'((int'(last_grant_q) + i) % NUM_SOURCES);
      if (!found && req[cand]) begin
        found   = 1'b1;
        grant_d = cand;
      end
    end
    ack_d          = '0;
    ack_d[grant_d] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_EMPTY;
      mask_q       <= '1;
      last_grant_q <= SRC_W'(NUM_SOURCES - 1);
      src_ack_q    <= '0;
      buf_write_q  <= 1'b0;
      buf_data_q   <= '0;
      data_ready_q <= 1'b0;
      src_id_q     <= '0;
      overrun_q    <= '0;
    end else begin
      // A new mask only affects arbitration from the following cycle.
      if (cfg_write) mask_q <= cfg_mask;
      unique case (state_q)
        S_EMPTY: begin
          if (|req) begin
            buf_data_q   <= src_data[32*grant_d +: 32];
            src_id_q     <= grant_d;
            last_grant_q <= grant_d;
            buf_write_q  <= 1'b1;
            src_ack_q    <= ack_d;
            state_q      <= S_WRITE;
          end
        end
        S_WRITE: begin
          buf_write_q <= 1'b0;
          src_ack_q   <= '0;
          if (flush) begin
            state_q <= S_EMPTY;
          end else begin
            data_ready_q <= 1'b1;
            state_q      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (|req && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
          if (flush || cpu_consume) begin
            data_ready_q <= 1'b0;
            state_q      <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign src_ack       = src_ack_q;
  assign buf_write     = buf_write_q;
  assign buf_data      = buf_data_q;
  assign data_ready    = data_ready_q;
  assign src_id        = src_id_q;
  assign overrun_count = overrun_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_io_input_arbiter.sv
// Bench for io_input_arbiter: reset checks, directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_io_input_arbiter;

  localparam int NS = 4;

  logic            clock;
  logic            reset_n;
  logic [NS-1:0]   src_valid;
  logic [32*NS-1:0] src_data;
  logic [NS-1:0]   src_ack;
  logic            buf_write;
  logic [31:0]     buf_data;
  logic            cpu_consume;
  logic            cfg_write;
  logic [NS-1:0]   cfg_mask;
  logic            flush;
  logic            data_ready;
  logic [1:0]      src_id;
  logic [7:0]      overrun_count;
  logic [1:0]      dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_model = 1'b0;

  io_input_arbiter #(.NUM_SOURCES(NS)) dut (
    .clock(clock), .reset_n(reset_n), .src_valid(src_valid), .src_data(src_data),
    .src_ack(src_ack), .buf_write(buf_write), .buf_data(buf_data),
    .cpu_consume(cpu_consume), .cfg_write(cfg_write), .cfg_mask(cfg_mask),
    .flush(flush), .data_ready(data_ready), .src_id(src_id),
    .overrun_count(overrun_count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The word's life is tracked as "write pulse pending" then "word held"; the
  // grant is the requester at the smallest circular distance past the last one.
  logic [NS-1:0] m_ack, m_mask, m_req;
  bit            m_write, m_ready;
  logic [31:0]   m_data;
  int            m_id, m_last, m_ovr, m_g;

  function automatic int rr_pick(input logic [NS-1:0] r, input int last);
    int best, best_d, d;
    best = -1; best_d = NS + 1;
    for (int i = 0; i < NS; i++) begin
      d = (i - last - 1 + 2 * NS) % NS;
      if (r[i] && d < best_d) begin best_d = d; best = i; end
    end
    return best;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ack = '0; m_write = 0; m_ready = 0; m_data = '0;
      m_id = 0; m_ovr = 0; m_mask = '1; m_last = NS - 1;
    end else begin
      m_req = src_valid & m_mask;
      if (m_write) begin
        m_write = 0; m_ack = '0; m_ready = !flush;
      end else if (m_ready) begin
        if (m_req != 0 && m_ovr < 255) m_ovr++;
        if (flush || cpu_consume) m_ready = 0;
      end else if (m_req != 0) begin
        m_g     = rr_pick(m_req, m_last);
        m_ack   = NS'(1) << m_g;
        m_write = 1;
        m_data  = src_data[32*m_g +: 32];
        m_id    = m_g;
        m_last  = m_g;
      end
      if (cfg_write) m_mask = cfg_mask;
    end
  end

  always @(negedge clock) begin
    if (chk_model) begin
      chk("rnd_ack",   32'(src_ack),       32'(m_ack));
      chk("rnd_write", 32'(buf_write),     32'(m_write));
      chk("rnd_ready", 32'(data_ready),    32'(m_ready));
      chk("rnd_data",  buf_data,           m_data);
      chk("rnd_id",    32'(src_id),        32'(m_id));
      chk("rnd_ovr",   32'(overrun_count), 32'(m_ovr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    src_valid = '0; cpu_consume = 0; cfg_write = 0; cfg_mask = '0; flush = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    repeat (2) step();
    reset_n = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NS-1:0] valid;
    logic          consume, flsh, cfgw;
    logic [NS-1:0] cmask;
    logic [NS-1:0] ack;
    logic          wr, rdy;
    logic [1:0]    id;
    logic [7:0]    ovr;
    logic [1:0]    st;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic [3:0] v, input bit c, input bit f, input bit w,
                              input logic [3:0] m, input logic [3:0] a, input bit wr,
                              input bit rdy, input int id, input int ovr, input int st);
    vec_t r;
    r.valid = v; r.consume = c; r.flsh = f; r.cfgw = w; r.cmask = m;
    r.ack = a; r.wr = wr; r.rdy = rdy; r.id = 2'(id); r.ovr = 8'(ovr); r.st = 2'(st);
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    src_data = '0;
    reset_n  = 0;
    do_reset();

    chk("rst_ack",   32'(src_ack),       32'h0);
    chk("rst_write", 32'(buf_write),     32'h0);
    chk("rst_data",  buf_data,           32'h0);
    chk("rst_ready", 32'(data_ready),    32'h0);
    chk("rst_id",    32'(src_id),        32'h0);
    chk("rst_ovr",   32'(overrun_count), 32'h0);
    chk("rst_state", 32'(dbg_state),     32'h0);

    // Single word from source 0: strobe one cycle, then ready until consumed.
    src_valid = 4'b0001;
    src_data[31:0] = 32'hDEADBEEF;
    step();
    chk("one_write", 32'(buf_write),  32'h1);
    chk("one_data",  buf_data,        32'hDEADBEEF);
    chk("one_ack",   32'(src_ack),    32'h1);
    chk("one_ready0", 32'(data_ready), 32'h0);
    src_valid = '0;
    step();
    chk("one_write_off", 32'(buf_write),  32'h0);
    chk("one_ack_off",   32'(src_ack),    32'h0);
    chk("one_ready",     32'(data_ready), 32'h1);
    chk("one_id",        32'(src_id),     32'h0);
    step();
    chk("one_ready_hold", 32'(data_ready), 32'h1);
    chk("one_data_hold",  buf_data,        32'hDEADBEEF);
    cpu_consume = 1;
    step();
    cpu_consume = 0;
    chk("one_consumed", 32'(data_ready), 32'h0);
    chk("one_empty",    32'(dbg_state),  32'h0);

    // Round robin, consume-in-write ignored, flush in write, mask change,
    // flush+consume together, valid dropping.
    //            valid c  f  w  mask  ack  wr rdy id ovr st
    tbl[0]  = mk(4'hF, 0, 0, 0, 4'h0, 4'h1, 1, 0, 0, 0, 1);
    tbl[1]  = mk(4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 1, 0, 0, 2);
    tbl[2]  = mk(4'hF, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(4'hF, 0, 0, 0, 4'h0, 4'h2, 1, 0, 1, 1, 1);
    tbl[4]  = mk(4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 1, 1, 1, 2);
    tbl[5]  = mk(4'hF, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1, 2, 0);
    tbl[6]  = mk(4'hF, 0, 0, 0, 4'h0, 4'h4, 1, 0, 2, 2, 1);
    tbl[7]  = mk(4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 1, 2, 2, 2);
    tbl[8]  = mk(4'hF, 1, 0, 0, 4'h0, 4'h0, 0, 0, 2, 3, 0);
    tbl[9]  = mk(4'hF, 0, 0, 0, 4'h0, 4'h8, 1, 0, 3, 3, 1);
    tbl[10] = mk(4'hF, 1, 0, 0, 4'h0, 4'h0, 0, 1, 3, 3, 2);
    tbl[11] = mk(4'hF, 1, 0, 0, 4'h0, 4'h0, 0, 0, 3, 4, 0);
    tbl[12] = mk(4'hF, 0, 0, 0, 4'h0, 4'h1, 1, 0, 0, 4, 1);
    tbl[13] = mk(4'hF, 0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 4, 0);
    tbl[14] = mk(4'hF, 0, 0, 1, 4'hA, 4'h2, 1, 0, 1, 4, 1);
    tbl[15] = mk(4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 1, 1, 4, 2);
    tbl[16] = mk(4'hF, 1, 1, 0, 4'h0, 4'h0, 0, 0, 1, 5, 0);
    tbl[17] = mk(4'hF, 0, 0, 0, 4'h0, 4'h8, 1, 0, 3, 5, 1);
    tbl[18] = mk(4'hF, 0, 0, 0, 4'h0, 4'h0, 0, 1, 3, 5, 2);
    tbl[19] = mk(4'hF, 1, 0, 0, 4'h0, 4'h0, 0, 0, 3, 6, 0);
    tbl[20] = mk(4'hF, 0, 0, 0, 4'h0, 4'h2, 1, 0, 1, 6, 1);
    tbl[21] = mk(4'h0, 0, 0, 0, 4'h0, 4'h0, 0, 1, 1, 6, 2);
    tbl[22] = mk(4'h0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1, 6, 0);
    tbl[23] = mk(4'h0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1, 6, 0);

    do_reset();
    for (int i = 0; i < NS; i++) src_data[32*i +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 24; i++) begin
      src_valid = tbl[i].valid; cpu_consume = tbl[i].consume; flush = tbl[i].flsh;
      cfg_write = tbl[i].cfgw;  cfg_mask = tbl[i].cmask;
      step();
      chk($sformatf("tbl%0d_ack", i),   32'(src_ack),       32'(tbl[i].ack));
      chk($sformatf("tbl%0d_write", i), 32'(buf_write),     32'(tbl[i].wr));
      chk($sformatf("tbl%0d_ready", i), 32'(data_ready),    32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_id", i),    32'(src_id),        32'(tbl[i].id));
      chk($sformatf("tbl%0d_ovr", i),   32'(overrun_count), 32'(tbl[i].ovr));
      chk($sformatf("tbl%0d_state", i), 32'(dbg_state),     32'(tbl[i].st));
      chk($sformatf("tbl%0d_data", i),  buf_data,           32'hA000_0000 + 32'(tbl[i].id));
    end
    idle_inputs();

    // Overrun: exactly 10 waiting cycles, then saturation.
    do_reset();
    src_valid = 4'b0001;
    step();
    src_valid = '0;
    step();
    src_valid = 4'b0010;
    repeat (10) step();
    src_valid = '0;
    step();
    chk("ovr_ten", 32'(overrun_count), 32'd10);
    src_valid = 4'b0010;
    repeat (300) step();
    chk("ovr_sat",       32'(overrun_count), 32'd255);
    chk("ovr_still_rdy", 32'(data_ready),    32'h1);
    flush = 1;
    step();
    flush = 0;
    src_valid = '0;
    chk("flush_hold_ready", 32'(data_ready), 32'h0);
    chk("flush_hold_state", 32'(dbg_state),  32'h0);
    chk("ovr_kept",         32'(overrun_count), 32'd255);

    // Asynchronous reset in the middle of a write cycle.
    do_reset();
    src_valid = 4'hF;
    step();
    step();
    cpu_consume = 1;
    step();
    cpu_consume = 0;
    step();
    chk("ar_pre_ack", 32'(src_ack), 32'h2);
    #1 reset_n = 0;
    #1;
    chk("ar_write", 32'(buf_write),  32'h0);
    chk("ar_ack",   32'(src_ack),    32'h0);
    chk("ar_ready", 32'(data_ready), 32'h0);
    #1 reset_n = 1;
    step();
    chk("ar_prio_ack", 32'(src_ack), 32'h1);
    idle_inputs();

    // Randomized run against the reference model.
    do_reset();
    chk_model = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      src_valid   = NS'($urandom_range(0, 15));
      src_data    = {$urandom, $urandom, $urandom, $urandom};
      cpu_consume = ($urandom_range(0, 99) < 30);
      flush       = ($urandom_range(0, 99) < 5);
      cfg_write   = ($urandom_range(0, 99) < 3);
      cfg_mask    = NS'($urandom_range(0, 15));
      step();
    end
    chk_model = 1'b0;
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_arbiter.md
Name: io_input_arbiter

Overview:
- Shares the CPU-side 32-bit input buffer among NUM_SOURCES IO devices.
- Picks one requesting device round-robin and drives the buffer write strobe and data for one cycle, then acks that device.
- Holds off further captures until the CPU consumes the word, and reports data_ready and the source id so software can poll the word through the buffer's load path.

Parameters:
- NUM_SOURCES, 4, number of IO requesters (2..8).
- SRC_W, $clog2(NUM_SOURCES), width of the source index (derived, not overridable).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- src_valid  input  NUM_SOURCES  per-device request; level, held until acked.
- src_data  input  32*NUM_SOURCES  per-device word; source i occupies bits [32*i+31:32*i].
- src_ack  output  NUM_SOURCES  one-cycle pulse to the granted device; one-hot or zero.
- buf_write  output  1  write strobe to input buffer.
- buf_data  output  32  word to input buffer io_in.
- cpu_consume  input  1  CPU has read the buffered word; pulse.
- cfg_write  input  1  load enable mask.
- cfg_mask  input  NUM_SOURCES  new enable mask; bit i=1 allows source i.
- flush  input  1  synchronous discard of the pending word.
- data_ready  output  1  buffer holds an unconsumed word.
- src_id  output  SRC_W  index of the source whose word is buffered.
- overrun_count  output  8  saturating count of cycles any enabled source waited while HOLD.

Behaviour:
- Reset (async, reset_n=0), all registered:
  - state=EMPTY; src_ack=0, buf_write=0, buf_data=0, data_ready=0, src_id=0, overrun_count=0.
  - enable mask=all ones; last_grant=NUM_SOURCES-1, so source 0 has first priority.
- States: EMPTY, WRITE, HOLD.
- EMPTY: req = src_valid & mask. If req!=0 at edge k:
  - grant = first set bit of req, searching from last_grant+1 upward with wrap.
  - Register buf_data<=src_data[grant], src_id<=grant, last_grant<=grant.
  - Assert buf_write=1 and src_ack[grant]=1 for cycle k+1; go WRITE.
- WRITE: lasts exactly one cycle. Next edge: buf_write=0, src_ack=0, data_ready<=1, go HOLD.
  - The input buffer captures at that same edge, so data_ready is never high before the buffer content is valid.
- HOLD:
  - buf_data stays stable.
  - cpu_consume=1 at an edge -> data_ready<=0, go EMPTY. A new grant is possible at the following edge, so min spacing is 3 cycles per word.
  - Each cycle in HOLD with req!=0 increments overrun_count, saturating at 255; it never wraps.
- cpu_consume in EMPTY or WRITE is ignored.
- flush=1:
  - In HOLD -> EMPTY, data_ready<=0.
  - In WRITE -> completes the write and ack (the source's word is accepted), then goes to EMPTY instead of HOLD, with data_ready staying 0.
  - Flush has priority over cpu_consume.
- cfg_write=1: mask<=cfg_mask at that edge. The new mask applies to arbitration from the next cycle. An in-flight WRITE/HOLD word is unaffected, even if its source is masked off.
- mask=0 or src_valid=0: stays in EMPTY, no strobes.
- A source that deasserts valid before grant is simply not selected; no partial transfers.
- overrun_count is cleared only by reset.

Test Plan:
- Reset then src_valid=4'b0001, src_data[0]=32'hDEADBEEF at edge k:
  - buf_write=1, buf_data=DEADBEEF, src_ack=0001 in cycle k+1 only.
  - data_ready=1, src_id=0 from cycle k+2.
  - cpu_consume at k+4 -> data_ready=0 at k+5.
- All four valid continuously, consume each word immediately: grant order 0,1,2,3,0 (src_ack 0001,0010,0100,1000,0001), one word every 3 cycles.
- Source 1 valid during a 10-cycle HOLD -> overrun_count=10. Hold 300 cycles -> saturates at 255.
- cfg_write with cfg_mask=4'b1010, all valid -> only sources 1 and 3 are granted, alternating.
- Flush:
  - flush during HOLD -> data_ready=0 next edge, state EMPTY.
  - flush in WRITE cycle -> ack pulse still seen, data_ready never rises.
  - flush and cpu_consume together behave as flush.
- reset_n low mid-WRITE (asynchronous, between edges) -> buf_write, src_ack, data_ready drop immediately. After release, source 0 has priority again.
